json_motor_cmd_tx: RTL and testbench

Parametrised JSON motor-command serialiser for the rover UART link. It accepts a signed left/right wheel speed pair in hundredths, formats it into the `{"T":<t>,"L":<l>,"R":<r>}\n` text frame, and streams the bytes over a valid/ready byte interface into `uart_tx`. Unlike the fixed-string generator it replaces, it formats arbitrary speeds at run time. It also trims trailing zeros, clamps out-of-range values, handles transmitter backpressure, and can periodically resend the last command as a keep-alive.

---
 rtl/json_motor_cmd_tx.sv | 169 ++++++++++++++++
 tb/tb_json_motor_cmd_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/json_motor_cmd_tx.sv
// Serialises a signed left/right wheel speed pair into a {"T":t,"L":l,"R":r}\n
// frame and streams it over a valid/ready byte interface, with optional keep-alive resend.
module json_motor_cmd_tx #(
    parameter int SPEED_W       = 8,
    parameter int T_CODE        = 1,
    parameter int RESEND_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic signed [SPEED_W-1:0] cmd_left,
    input  logic signed [SPEED_W-1:0] cmd_right,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic                      frame_done,
    output logic [4:0]                frame_len
);

    localparam int CNT_W = (RESEND_CYCLES > 0) ? $clog2(RESEND_CYCLES + 1) : 1;
    localparam logic signed [SPEED_W-1:0] MAX_S = SPEED_W'(100);
    localparam logic signed [SPEED_W-1:0] MIN_S = -MAX_S;
    localparam logic [7:0] T_CHAR = 8'(8'h30 + T_CODE);

    typedef enum logic [1:0] {IDLE, BUILD, SEND} state_t;

    // Number text, right-aligned in s; n = character count (1..5).
    typedef struct packed {
        logic [2:0]  n;
        logic [39:0] s;
    } num_t;

    function automatic num_t fmt_num(input logic signed [SPEED_W-1:0] v);
        logic signed [SPEED_W-1:0] c;
        logic [SPEED_W-1:0] mag;
        logic [6:0] a;
        logic [6:0] frac;
        logic [3:0] tens;
        logic [3:0] units;
        num_t r;
        c = v;
        if (v > MAX_S)
            c = MAX_S;
        else if (v < MIN_S)
            c = MIN_S;
        mag   = c[SPEED_W-1] ? -c : c;
        a     = mag[6:0];
        frac  = (a == 7'd100) ? 7'd0 : a;
        tens  = 4'(frac / 7'd10);
        units = 4'(frac % 7'd10);
        r = '0;
        if (c[SPEED_W-1]) begin
            r.s = {r.s[31:0], 8'h2d};
            r.n = r.n + 3'd1;
        end
        r.s = {r.s[31:0], (a == 7'd100) ? 8'h31 : 8'h30};
        r.n = r.n + 3'd1;
        if (frac != 7'd0) begin
            r.s = {r.s[23:0], 8'h2e, 4'h3, tens};
            r.n = r.n + 3'd2;
            if (units != 4'd0) begin
                r.s = {r.s[31:0], 4'h3, units};
                r.n = r.n + 3'd1;
            end
        end
        return r;
    endfunction

    state_t                    state;
    logic signed [SPEED_W-1:0] lat_left;
    logic signed [SPEED_W-1:0] lat_right;
    logic                      have_cmd;
    logic [CNT_W-1:0]          resend_cnt;
    logic [223:0]              frame_q;
    logic [4:0]                idx;

    num_t         num_l;
    num_t         num_r;
    logic [223:0] frame_c;
    logic [4:0]   len_c;
    logic [4:0]   sel_first;
    logic [4:0]   sel_next;

    // Frame is built by shifting text in from the right, so byte 0 ends up highest.
    always_comb begin
        num_l   = fmt_num(lat_left);
        num_r   = fmt_num(lat_right);
        frame_c = '0;
        frame_c[47:0] = {"{\"T\":", T_CHAR};
        frame_c = {frame_c[183:0], ",\"L\":"};
        frame_c = (frame_c << {num_l.n, 3'b000}) | {184'd0, num_l.s};
        frame_c = {frame_c[183:0], ",\"R\":"};
        frame_c = (frame_c << {num_r.n, 3'b000}) | {184'd0, num_r.s};
        frame_c = {frame_c[207:0], "}\n"};
        len_c   = 5'd18 + {2'b00, num_l.n} + {2'b00, num_r.n};
    end

    assign sel_first = frame_len - 5'd1;
    assign sel_next  = frame_len - 5'd2 - idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_left   <= '0;
            lat_right  <= '0;
            have_cmd   <= 1'b0;
            resend_cnt <= '0;
            frame_q    <= '0;
            idx        <= '0;
            cmd_ready  <= 1'b1;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= 5'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        lat_left   <= cmd_left;
                        lat_right  <= cmd_right;
                        have_cmd   <= 1'b1;
                        resend_cnt <= '0;
                        cmd_ready  <= 1'b0;
                        state      <= BUILD;
                    end else if (RESEND_CYCLES > 0 && have_cmd) begin
                        if (resend_cnt == CNT_W'(RESEND_CYCLES)) begin
                            resend_cnt <= '0;
                            cmd_ready  <= 1'b0;
                            state      <= BUILD;
                        end else begin
                            resend_cnt <= resend_cnt + 1'b1;
                        end
                    end
                end
                BUILD: begin
                    frame_q   <= frame_c;
                    frame_len <= len_c;
                    busy      <= 1'b1;
                    idx       <= '0;
                    state     <= SEND;
                end
                SEND: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= frame_q[{sel_first, 3'b000} +: 8];
                    end else if (tx_ready) begin
                        if (idx == sel_first) begin
                            tx_valid   <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            cmd_ready  <= 1'b1;
                            resend_cnt <= '0;
                            state      <= IDLE;
                        end else begin
                            idx     <= idx + 5'd1;
                            tx_data <= frame_q[{sel_next, 3'b000} +: 8];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_json_motor_cmd_tx.sv
// Scoreboard bench for json_motor_cmd_tx: expected frame bytes are queued when a
// command is driven and compared as the serialiser hands bytes to the UART side.
module tb_json_motor_cmd_tx;

    localparam int SW     = 8;
    localparam int RESEND = 1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [SW-1:0] cmd_left;
    logic [SW-1:0] cmd_right;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          frame_done;
    logic [4:0]    frame_len;

    json_motor_cmd_tx #(.SPEED_W(SW), .T_CODE(1), .RESEND_CYCLES(RESEND)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_left   (cmd_left),
        .cmd_right  (cmd_right),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_len  (frame_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    int         len_q[$];
    int         frame_bytes = 0;
    int         valid_seen  = 0;
    int         done_seen   = 0;
    bit         rand_ready  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    endtask

    function automatic string fmt_speed(input int v);
        int    a;
        string s;
        if (v > 100) v = 100;
        if (v < -100) v = -100;
        a = (v < 0) ? -v : v;
        s = (v < 0) ? "-" : "";
        if (a == 100)          s = {s, "1"};
        else if (a == 0)       s = {s, "0"};
        else if (a % 10 == 0)  s = {s, $sformatf("0.%0d", a / 10)};
        else                   s = {s, $sformatf("0.%02d", a)};
        return s;
    endfunction

    function automatic string model_frame(input int l, input int r);
        return $sformatf("{\"T\":1,\"L\":%s,\"R\":%s}\n", fmt_speed(l), fmt_speed(r));
    endfunction

    task automatic push_frame(input string f);
        for (int i = 0; i < f.len(); i++)
            exp_q.push_back(f[i]);
        len_q.push_back(f.len());
    endtask

    // Drive one command, optionally spam ignored commands, wait for frame_done.
    task automatic send_cmd(input int l, input int r, input string f, input bit spam);
        int k;
        bit done;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_left  = SW'(l);
        cmd_right = SW'(r);
        cmd_valid = 1'b1;
        push_frame(f);
        @(posedge clk);
        k    = 0;
        done = 1'b0;
        while (!done && k < 400) begin
            @(negedge clk);
            if (k == 0) chk("busy_before", busy, 0);
            if (k == 1) chk("busy_after", busy, 1);
            if (frame_done) begin
                done      = 1'b1;
                cmd_valid = 1'b0;
            end else begin
                if (spam) begin
                    chk("cmd_ready_busy", cmd_ready, 0);
                    cmd_valid = 1'b1;
                    cmd_left  = SW'($urandom_range(0, 255));
                    cmd_right = SW'($urandom_range(0, 255));
                end else begin
                    cmd_valid = 1'b0;
                end
                @(posedge clk);
                k++;
            end
        end
        chk("frame_timeout", done, 1);
        chk("cmd_ready_back", cmd_ready, 1);
        chk("busy_clear", busy, 0);
        if (!rand_ready) chk("latency", k, f.len() + 2);
        @(negedge clk);
        chk("done_pulse_width", frame_done, 0);
    endtask

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: a byte counts when valid && ready hold going into the next rising edge.
    initial begin
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        int         el;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall  = 1'b0;
                frame_bytes = 0;
            end else begin
                if (tx_valid) valid_seen++;
                if (prev_stall) begin
                    chk("valid_hold", tx_valid, 1);
                    if (tx_valid) chk("stall_hold", tx_data, prev_data);
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) chk("extra_byte", tx_valid, 0);
                    else                   chk("byte", tx_data, exp_q.pop_front());
                    frame_bytes++;
                end
                if (frame_done) begin
                    if (len_q.size() == 0) begin
                        chk("extra_done", frame_done, 0);
                    end else begin
                        el = len_q.pop_front();
                        chk("frame_len", frame_len, el);
                        chk("frame_bytes", frame_bytes, el);
                    end
                    frame_bytes = 0;
                    done_seen++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_checks=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int v0;
        int d0;
        int l;
        int r;
        bit done;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_left  = '0;
        cmd_right = '0;
        #3;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_len", frame_len, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("idle_no_valid", valid_seen, 0);

        send_cmd(-25, 25, "{\"T\":1,\"L\":-0.25,\"R\":0.25}\n", 1'b0);
        send_cmd(50, 50, "{\"T\":1,\"L\":0.5,\"R\":0.5}\n", 1'b0);
        send_cmd(0, 0, "{\"T\":1,\"L\":0,\"R\":0}\n", 1'b0);
        send_cmd(5, -100, "{\"T\":1,\"L\":0.05,\"R\":-1}\n", 1'b0);
        send_cmd(127, -128, "{\"T\":1,\"L\":1,\"R\":-1}\n", 1'b0);
        send_cmd(-7, 30, model_frame(-7, 30), 1'b1);

        rand_ready = 1'b1;
        send_cmd(-25, 25, "{\"T\":1,\"L\":-0.25,\"R\":0.25}\n", 1'b1);
        for (int i = 0; i < 6; i++) begin
            l = int'($urandom_range(0, 255)) - 128;
            r = int'($urandom_range(0, 255)) - 128;
            send_cmd(l, r, model_frame(l, r), i[0]);
        end
        rand_ready = 1'b0;
        chk("sb_empty", exp_q.size(), 0);

        // Keep-alive: last command repeats after RESEND idle cycles plus frame time.
        send_cmd(25, -25, "{\"T\":1,\"L\":0.25,\"R\":-0.25}\n", 1'b0);
        push_frame("{\"T\":1,\"L\":0.25,\"R\":-0.25}\n");
        k    = 0;
        done = 1'b0;
        while (!done && k < 1200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (frame_done) done = 1'b1;
        end
        chk("resend_seen", done, 1);
        chk("resend_gap_ok", (k >= RESEND + 27 && k <= RESEND + 33), 1);

        push_frame("{\"T\":1,\"L\":0.25,\"R\":-0.25}\n");
        k = 0;
        while (frame_bytes < 10 && k < 1200) begin
            @(negedge clk);
            k++;
        end
        chk("resend2_timeout", (frame_bytes >= 10), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_frame_len", frame_len, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_frame_done", frame_done, 0);
        exp_q.delete();
        len_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        v0 = valid_seen;
        d0 = done_seen;
        repeat (1200) @(negedge clk);
        chk("post_rst_no_valid", valid_seen - v0, 0);
        chk("post_rst_no_done", done_seen - d0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
